// File: rtl/hp35_phase_gen.sv
// hp35_phase_gen: divided clock plus non-overlapping two-phase pair.
// Half period H is 2^min(tap, CNT_W-1) (mode 0) or div+1 (mode 1).
// New configuration is staged in pending registers and is applied only
// on a clk_out falling edge, or right away while the divider is idle.
module hp35_phase_gen #(
    parameter int CNT_W  = 8,
    parameter int TAP_W  = 3,
    parameter int DEAD_W = 3
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              en,
    input  logic              cfg_we,
    input  logic              cfg_mode,
    input  logic [TAP_W-1:0]  cfg_tap,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [DEAD_W-1:0] cfg_dead,
    output logic              cfg_busy,
    output logic              clk_out,
    output logic              phi1,
    output logic              phi2,
    output logic              tick
);

    localparam int CMP_W = (CNT_W > DEAD_W) ? CNT_W : DEAD_W;

    // divider and output registers
    logic [CNT_W-1:0]  r_hc;
    logic              r_clk;
    logic              r_phi1;
    logic              r_phi2;
    logic              r_tick;

    // active configuration
    logic              r_mode;
    logic [TAP_W-1:0]  r_tap;
    logic [CNT_W-1:0]  r_div;
    logic [DEAD_W-1:0] r_dead;

    // pending configuration
    logic              r_p_mode;
    logic [TAP_W-1:0]  r_p_tap;
    logic [CNT_W-1:0]  r_p_div;
    logic [DEAD_W-1:0] r_p_dead;
    logic              r_busy;

    logic [TAP_W-1:0]  w_sh;
    logic [CNT_W-1:0]  w_hmax;
    logic              w_wrap;
    logic              w_apply;
    logic [CNT_W-1:0]  w_hc_nxt;
    logic              w_clk_nxt;
    logic [DEAD_W-1:0] w_dead_nxt;
    logic              w_ge;

    // Next-state of the divider; phases are derived from the next-state
    // counter/clock and the dead time that will be active after this edge.
    // H-1 is compared directly, so H = 2^CNT_W never needs an extra bit.
    always_comb begin
        w_sh       = (r_tap > TAP_W'(CNT_W - 1)) ? TAP_W'(CNT_W - 1) : r_tap;
        w_hmax     = r_mode ? r_div : ((CNT_W'(1) << w_sh) - CNT_W'(1));
        w_wrap     = (r_hc == w_hmax);
        w_apply    = r_busy & (~en | (w_wrap & r_clk));
        w_hc_nxt   = '0;
        w_clk_nxt  = 1'b0;
        if (en) begin
            w_hc_nxt  = w_wrap ? '0 : (r_hc + CNT_W'(1));
            w_clk_nxt = r_clk ^ w_wrap;
        end
        w_dead_nxt = w_apply ? r_p_dead : r_dead;
        w_ge       = (CMP_W'(w_hc_nxt) >= CMP_W'(w_dead_nxt));
    end

    // Divider counter, divided clock, phases and tick.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_hc   <= '0;
            r_clk  <= 1'b0;
            r_phi1 <= 1'b0;
            r_phi2 <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_hc   <= w_hc_nxt;
            r_clk  <= w_clk_nxt;
            r_phi1 <= w_clk_nxt & w_ge;
            r_phi2 <= ~w_clk_nxt & w_ge & en;
            r_tick <= w_clk_nxt & ~r_clk;
        end
    end

    // Staging: a write while busy simply overwrites the pending values.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_p_mode <= 1'b0;
            r_p_tap  <= '0;
            r_p_div  <= '0;
            r_p_dead <= DEAD_W'(1);
            r_busy   <= 1'b0;
        end else begin
            if (cfg_we) begin
                r_p_mode <= cfg_mode;
                r_p_tap  <= cfg_tap;
                r_p_div  <= cfg_div;
                r_p_dead <= cfg_dead;
            end
            r_busy <= cfg_we | (r_busy & ~w_apply);
        end
    end

    // Apply: a write coinciding with the apply cycle lands in pending and
    // waits, while the previously pending values move to active here.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_mode <= 1'b0;
            r_tap  <= '0;
            r_div  <= '0;
            r_dead <= DEAD_W'(1);
        end else if (w_apply) begin
            r_mode <= r_p_mode;
            r_tap  <= r_p_tap;
            r_div  <= r_p_div;
            r_dead <= r_p_dead;
        end
    end

    assign cfg_busy = r_busy;
    assign clk_out  = r_clk;
    assign phi1     = r_phi1;
    assign phi2     = r_phi2;
    assign tick     = r_tick;

endmodule

// File: tb/tb_hp35_phase_gen.sv
// Directed testbench for hp35_phase_gen (default CNT_W=8 plus a CNT_W=4 copy
// for the tap clamp).
module tb_hp35_phase_gen;

    logic       clk;
    logic       rst_n;

    logic       en, we, mode;
    logic [2:0] tap;
    logic [7:0] div;
    logic [2:0] dead;
    logic       busy, clk_o, p1, p2, tk;

    logic       en4, we4, mode4;
    logic [2:0] tap4;
    logic [3:0] div4;
    logic [2:0] dead4;
    logic       busy4, clk_o4, p14, p24, tk4;

    int n_checks = 0;
    int n_fail   = 0;

    hp35_phase_gen dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .en       (en),
        .cfg_we   (we),
        .cfg_mode (mode),
        .cfg_tap  (tap),
        .cfg_div  (div),
        .cfg_dead (dead),
        .cfg_busy (busy),
        .clk_out  (clk_o),
        .phi1     (p1),
        .phi2     (p2),
        .tick     (tk)
    );

    hp35_phase_gen #(.CNT_W(4), .TAP_W(3), .DEAD_W(3)) dut4 (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .en       (en4),
        .cfg_we   (we4),
        .cfg_mode (mode4),
        .cfg_tap  (tap4),
        .cfg_div  (div4),
        .cfg_dead (dead4),
        .cfg_busy (busy4),
        .clk_out  (clk_o4),
        .phi1     (p14),
        .phi2     (p24),
        .tick     (tk4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks samples m = first..last counted from the state hc=0, clk_out=0,
    // using half period h: clk_out = (m/h)%2, hc = m%h.
    task automatic run_phase(input bit sel, input int h, input int dd,
                             input int first, input int last, input bit exp_busy);
        for (int m = first; m <= last; m++) begin
            int  hcv;
            bit  ec, ge;
            step();
            hcv = m % h;
            ec  = ((m / h) % 2) == 1;
            ge  = hcv >= dd;
            check($sformatf("clk_out@%0d/H%0d", m, h), sel ? clk_o4 : clk_o, 32'(ec));
            check($sformatf("phi1@%0d/H%0d", m, h), sel ? p14 : p1, 32'(ec & ge));
            check($sformatf("phi2@%0d/H%0d", m, h), sel ? p24 : p2, 32'(!ec & ge));
            check($sformatf("tick@%0d/H%0d", m, h), sel ? tk4 : tk, 32'((m % (2 * h)) == h));
            check($sformatf("busy@%0d/H%0d", m, h), sel ? busy4 : busy, 32'(exp_busy));
        end
    endtask

    task automatic apply_idle(input logic m_i, input logic [2:0] t_i,
                              input logic [7:0] d_i, input logic [2:0] dd_i);
        en = 1'b0;
        step();
        mode = m_i; tap = t_i; div = d_i; dead = dd_i;
        we = 1'b1;
        step();
        we = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        en = 0; we = 0; mode = 0; tap = 0; div = 0; dead = 0;
        en4 = 0; we4 = 0; mode4 = 0; tap4 = 0; div4 = 0; dead4 = 0;
        repeat (3) step();
        check("rst_clk_out", clk_o, 0);
        check("rst_phi1", p1, 0);
        check("rst_phi2", p2, 0);
        check("rst_tick", tk, 0);
        check("rst_busy", busy, 0);
        check("rst_clk_out4", clk_o4, 0);
        rst_n = 1'b1;
        step();

        // defaults: H=1, dead=1 -> period 2, no phases
        en = 1'b1;
        run_phase(0, 1, 1, 1, 8, 0);

        // mode 1 div 4 dead 1 applied while idle -> H=5
        en = 1'b0;
        step();
        mode = 1; div = 8'd4; dead = 3'd1;
        we = 1'b1;
        step();
        we = 1'b0;
        check("idle_busy_set", busy, 1);
        step();
        check("idle_busy_clr", busy, 0);
        en = 1'b1;
        run_phase(0, 5, 1, 1, 25, 0);

        // tap 3 (H=8), reconfigure mid high half to div 2 (H=3)
        apply_idle(1'b0, 3'd3, 8'd0, 3'd2);
        en = 1'b1;
        run_phase(0, 8, 2, 1, 26, 0);
        mode = 1; div = 8'd2; dead = 3'd1;
        we = 1'b1;
        run_phase(0, 8, 2, 27, 27, 1);
        we = 1'b0;
        run_phase(0, 8, 2, 28, 31, 1);
        run_phase(0, 3, 1, 0, 15, 0);

        // two strobes in one high half: only the last (div 1, H=2) applies
        div = 8'd6;
        we = 1'b1;
        run_phase(0, 3, 1, 16, 16, 1);
        div = 8'd1;
        run_phase(0, 3, 1, 17, 17, 1);
        we = 1'b0;
        run_phase(0, 2, 1, 0, 7, 0);

        // div 255 -> H=256, dead 0 gives complementary phases
        apply_idle(1'b1, 3'd0, 8'd255, 3'd0);
        en = 1'b1;
        run_phase(0, 256, 0, 1, 520, 0);

        // CNT_W=4: tap 7 clamps to H=8
        mode4 = 0; tap4 = 3'd7; dead4 = 3'd0;
        we4 = 1'b1;
        step();
        we4 = 1'b0;
        step();
        en4 = 1'b1;
        run_phase(1, 8, 0, 1, 20, 0);

        // reset mid high half with a pending config
        apply_idle(1'b1, 3'd0, 8'd4, 3'd1);
        en = 1'b1;
        run_phase(0, 5, 1, 1, 7, 0);
        div = 8'd2;
        we = 1'b1;
        run_phase(0, 5, 1, 8, 8, 1);
        we = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_clk_out", clk_o, 0);
        check("arst_phi1", p1, 0);
        check("arst_busy", busy, 0);
        check("arst_clk_out4", clk_o4, 0);
        step();
        check("rst_hold_clk_out", clk_o, 0);
        check("rst_hold_busy", busy, 0);
        rst_n = 1'b1;
        run_phase(0, 1, 1, 1, 6, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hp35_phase_gen.md
# hp35_phase_gen

Parametrised successor to the fixed 8-way clock-divider select that feeds the HP-35 core's `osc_in`. It generates a divided clock `clk_out` plus a non-overlapping two-phase pair `phi1`/`phi2` from a single system clock. Two divide modes are available: power-of-two tap and arbitrary integer. Reconfiguration is glitch-free: it is staged and applied only on a falling edge of `clk_out`. The block sits between the LA/debug control bits and the core clock inputs.

## Interface
- `CNT_W`, default 8: width of the half-period counter and of `div_val`.
- `TAP_W`, default 3: width of `tap_sel`; must satisfy 2^TAP_W ≥ CNT_W.
- `DEAD_W`, default 3: width of the dead-time field.
- `wb_clk_i`  in  1  system clock; all logic is on the rising edge.
- `wb_rst_ni`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable; when low, the divider is held idle.
- `cfg_we`  in  1  one-cycle strobe that stages the `cfg_*` inputs.
- `cfg_mode`  in  1  0 = power-of-two tap, 1 = integer divide.
- `cfg_tap`  in  TAP_W  tap select (mode 0).
- `cfg_div`  in  CNT_W  divide value (mode 1).
- `cfg_dead`  in  DEAD_W  dead time in cycles at the start of each half period.
- `cfg_busy`  out  1  high while a staged configuration is pending.
- `clk_out`  out  1  divided clock (registered).
- `phi1`  out  1  phase 1; subset of the `clk_out` high half.
- `phi2`  out  1  phase 2; subset of the `clk_out` low half.
- `tick`  out  1  one-cycle pulse coincident with each `clk_out` rising edge.

## Operation
- Active configuration: `mode`, `tap`, `div`, `dead`. Reset values: mode 0, tap 0, div 0, dead 1.
- Half period H:
  - Mode 0: H = 2^min(tap, CNT_W-1).
  - Mode 1: H = div+1, so the range is 1..2^CNT_W.
  - `hc` is CNT_W bits wide and holds 0..H-1.
- Divider with en=1:
  - `hc` increments each cycle.
  - When hc == H-1: hc←0 and `clk_out` toggles.
  - Output period is 2H cycles at 50% duty.
- Divider with en=0 (synchronous):
  - hc←0, `clk_out`←0, `phi1`/`phi2`/`tick`←0.
  - The next en=1 cycle starts a low half with hc=0.
- Phases (registered, aligned with `clk_out`, evaluated on the next-state values):
  - `phi1` = clk_out & (hc ≥ dead).
  - `phi2` = ~clk_out & (hc ≥ dead) & en.
  - Each phase is high for H−dead cycles per half when dead < H, and never when dead ≥ H.
  - `phi1` & `phi2` is never 1.
  - dead=0 gives complementary phases with no gap.
- `tick`: high in the first cycle that `clk_out` is 1 after being 0.
- Staging:
  - `cfg_we` copies the `cfg_*` inputs into the pending registers and sets `cfg_busy`.
  - A `cfg_we` while busy overwrites the pending values; busy stays 1.
- Apply:
  - With en=1: the pending values become active in the same cycle `clk_out` toggles 1→0. The new H governs that low half (hc=0). `cfg_busy` clears in that same cycle.
  - With en=0: the pending values are applied in the cycle after `cfg_we`.
  - If `cfg_we` coincides with the apply cycle, the newly written values are staged and await the next falling edge. The older pending values are applied.
- No partial or runt pulses are permitted on `clk_out`, `phi1` or `phi2` across reconfiguration or en changes, except that en=0 truncates the current half.

## Timing
- Reset (async assert, sync-released use):
  - `clk_out`, `phi1`, `phi2`, `tick`, `cfg_busy` = 0.
  - hc = 0; active and pending config are at their reset values.
- From en sampled high at cycle 0: `clk_out` rises at cycle H (registered), `tick`=1 in that cycle, and it falls at cycle 2H.
- `cfg_busy` rises 1 cycle after `cfg_we`.
- Worst-case apply latency with en=1 is 2H_old+1 cycles.
- Reset mid-operation: all outputs 0 immediately, and any pending config is discarded.
- Counter arithmetic: hc compare uses CNT_W bits. With mode 1 and div = 2^CNT_W−1, H = 2^CNT_W and hc wraps at all-ones without overflow.

## Test plan
- Reset, then en=1 with defaults (mode 0, tap 0, dead 1) -> `clk_out` period 2 with H=1. `phi1`/`phi2` stay 0 because dead ≥ H. `tick` every 2 cycles.
- Mode 1, div=4, dead=1, applied while en=0 -> `clk_out` period 10 (5 high / 5 low). `phi1` high 4 cycles starting 1 cycle after the rising edge, `phi2` likewise in the low half, never overlapping.
- Running mode 0 tap 3 (period 16); `cfg_we` with mode 1 div=2 issued mid high-half -> `cfg_busy`=1 until the falling edge. The next low half is 3 cycles; no `clk_out` high pulse shorter than 8 cycles or longer than 8 cycles occurs before the switch.
- Two `cfg_we` strobes (div=6, then div=1) before the falling edge -> only div=1 applied (period 4); `cfg_busy` clears at that edge.
- Mode 1 with div = 2^CNT_W−1 (255) -> H=256, period 512, no hc overflow. `cfg_tap`=7 with CNT_W=4 clamps to H=8.
- `wb_rst_ni` pulsed low mid high-half with a pending config -> outputs 0 immediately; after release, defaults are active and `cfg_busy`=0.
